// File: rtl/commutation_scheduler.sv
// Sequences the three per-phase commutation FSMs of the matrix converter one phase at a time,
// with a settle window after each change and a latched fault path that parks every phase in BAD.
module commutation_scheduler #(
   parameter int DWELL_W       = 16,
   parameter int SETTLE_CYCLES = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pat_valid,
   output logic               pat_ready,
   input  logic [5:0]         pat_sel,
   input  logic [DWELL_W-1:0] pat_dwell,
   input  logic               fault,
   input  logic               fault_clr,
   output logic [5:0]         desired_load,
   output logic               fsm_rst,
   output logic               busy,
   output logic [1:0]         cur_phase,
   output logic               fault_latched
);

   localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
   localparam logic [1:0] PH_A = 2'd0;
   localparam logic [1:0] PH_C = 2'd2;

   typedef enum logic [2:0] {
      S_INIT, S_IDLE, S_SCAN, S_COMMUTE, S_DWELL, S_FAULT
   } state_t;

   state_t             state, state_nxt;
   logic [5:0]         target, target_nxt;
   logic [DWELL_W-1:0] dwell, dwell_nxt;
   logic [1:0]         k, k_nxt;
   logic [SET_W-1:0]   settle_cnt, settle_nxt;
   logic [5:0]         dl_nxt;
   logic               fsm_rst_nxt, ready_nxt, busy_nxt, flt_nxt;
   logic [1:0]         phase_nxt;

   logic [1:0] tgt_k;
   logic [1:0] cur_k;
   logic       scan_hit;
   logic       fault_hit;
   logic       no_dwell;
   state_t     end_state;

   assign tgt_k     = target[2*k +: 2];
   assign cur_k     = desired_load[2*k +: 2];
   assign scan_hit  = (tgt_k != 2'b00) && (tgt_k != cur_k);
   assign fault_hit = fault && (state != S_INIT) && (state != S_FAULT);
   assign no_dwell  = (dwell == '0);
   assign end_state = no_dwell ? S_IDLE : S_DWELL;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= S_INIT;
         target        <= '0;
         dwell         <= '0;
         k             <= '0;
         settle_cnt    <= '0;
         desired_load  <= '0;
         fsm_rst       <= 1'b1;
         pat_ready     <= 1'b0;
         busy          <= 1'b0;
         cur_phase     <= '0;
         fault_latched <= 1'b0;
      end else begin
         state         <= state_nxt;
         target        <= target_nxt;
         dwell         <= dwell_nxt;
         k             <= k_nxt;
         settle_cnt    <= settle_nxt;
         desired_load  <= dl_nxt;
         fsm_rst       <= fsm_rst_nxt;
         pat_ready     <= ready_nxt;
         busy          <= busy_nxt;
         cur_phase     <= phase_nxt;
         fault_latched <= flt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_INIT:    state_nxt = S_IDLE;
         S_IDLE:    if (pat_valid && pat_ready) state_nxt = S_SCAN;
         S_SCAN: begin
            if (scan_hit)        state_nxt = S_COMMUTE;
            else if (k != PH_C)  state_nxt = S_SCAN;
            else                 state_nxt = end_state;
         end
         S_COMMUTE: if (settle_cnt == '0) state_nxt = (k != PH_C) ? S_SCAN : end_state;
         S_DWELL:   if (dwell == DWELL_W'(1)) state_nxt = S_IDLE;
         S_FAULT:   if (fault_clr && !fault) state_nxt = S_IDLE;
         default:   state_nxt = S_INIT;
      endcase
      if (fault_hit) state_nxt = S_FAULT;
   end

   always_comb begin
      target_nxt  = target;
      dwell_nxt   = dwell;
      k_nxt       = k;
      settle_nxt  = settle_cnt;
      dl_nxt      = desired_load;
      fsm_rst_nxt = fsm_rst;
      ready_nxt   = pat_ready;
      busy_nxt    = busy;
      phase_nxt   = cur_phase;
      flt_nxt     = fault_latched;
      case (state)
         S_INIT: begin
            fsm_rst_nxt = 1'b0;
            ready_nxt   = 1'b1;
         end
         S_IDLE: begin
            if (pat_valid && pat_ready) begin
               target_nxt = pat_sel;
               dwell_nxt  = pat_dwell;
               ready_nxt  = 1'b0;
               busy_nxt   = 1'b1;
               k_nxt      = PH_A;
            end
         end
         S_SCAN: begin
            if (scan_hit) begin
               dl_nxt[2*k +: 2] = tgt_k;
               phase_nxt        = k + 2'd1;
               settle_nxt       = SETTLE_LAST;
            end else if (k != PH_C) begin
               k_nxt = k + 2'd1;
            end else if (no_dwell) begin
               ready_nxt = 1'b1;
               busy_nxt  = 1'b0;
            end
         end
         S_COMMUTE: begin
            if (settle_cnt == '0) begin
               phase_nxt = 2'd0;
               if (k != PH_C) begin
                  k_nxt = k + 2'd1;
               end else if (no_dwell) begin
                  ready_nxt = 1'b1;
                  busy_nxt  = 1'b0;
               end
            end else begin
               settle_nxt = settle_cnt - 1'b1;
            end
         end
         S_DWELL: begin
            // dwell doubles as the down-counter; entry guarantees it is non-zero
            dwell_nxt = dwell - 1'b1;
            if (dwell == DWELL_W'(1)) begin
               ready_nxt = 1'b1;
               busy_nxt  = 1'b0;
            end
         end
         S_FAULT: begin
            if (fault_clr && !fault) begin
               fsm_rst_nxt = 1'b0;
               flt_nxt     = 1'b0;
               ready_nxt   = 1'b1;
            end
         end
         default: ;
      endcase
      if (fault_hit) begin
         dl_nxt      = '0;
         fsm_rst_nxt = 1'b1;
         flt_nxt     = 1'b1;
         ready_nxt   = 1'b0;
         busy_nxt    = 1'b0;
         phase_nxt   = 2'd0;
      end
   end

endmodule
